// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM state
// encodings and the lane-mask / store-replicate / load-extend helpers.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Mask is built for the widest (64-bit) bus; narrower users truncate it.
    function automatic logic [7:0] byte_en_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [8:0] span;
        span = (9'd1 << (4'd1 << size)) - 9'd1;
        return span[7:0] << offset;
    endfunction

    function automatic logic [63:0] store_replicate(input logic [1:0] size, input logic [63:0] wdata);
        logic [63:0] rep;
        case (size)
            SZ_BYTE: rep = {8{wdata[7:0]}};
            SZ_HALF: rep = {4{wdata[15:0]}};
            SZ_WORD: rep = {2{wdata[31:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                                input logic [2:0] offset, input logic sign_ext);
        logic [63:0] sh;
        logic [63:0] ext;
        sh = raw >> {offset, 3'b000};
        case (size)
            SZ_BYTE: ext = {{56{sign_ext & sh[7]}},  sh[7:0]};
            SZ_HALF: ext = {{48{sign_ext & sh[15]}}, sh[15:0]};
            SZ_WORD: ext = {{32{sign_ext & sh[31]}}, sh[31:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Core-request / response / data-memory signal bundle for dm_access_unit.
// slave = the access unit itself, master = core plus memory environment.
interface dm_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_signed;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_error;
    logic                      DM_enable;
    logic                      DM_read;
    logic                      DM_write;
    logic [ADDR_WIDTH-1:0]     DM_address;
    logic [DATA_WIDTH/8-1:0]   DM_byte_en;
    logic [DATA_WIDTH-1:0]     DM_in;
    logic [DATA_WIDTH-1:0]     DM_out;
    logic                      DM_ready;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, DM_out, DM_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output DM_enable, DM_read, DM_write, DM_address, DM_byte_en, DM_in
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, DM_out, DM_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  DM_enable, DM_read, DM_write, DM_address, DM_byte_en, DM_in
    );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational byte-lane alignment: lane enables, store replication and
// load extract/extend for a DATA_WIDTH-bit memory word.
module dm_lane_align
    import dm_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB         = DATA_WIDTH / 8,
    localparam int unsigned OFFW       = $clog2(NB)
) (
    input  logic [1:0]            size_i,
    input  logic [OFFW-1:0]       offset_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [NB-1:0]         byte_en_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    always_comb begin
        byte_en_o = NB'(byte_en_mask(size_i, 3'(offset_i)));
        wdata_o   = DATA_WIDTH'(store_replicate(size_i, 64'(wdata_i)));
        rdata_o   = DATA_WIDTH'(load_extend(64'(rdata_i), size_i, 3'(offset_i), signed_i));
    end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: byte/half/word/dword accesses with a wait-state
// handshake. Optional access timeout enabled by defining DM_TIMEOUT_EN.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic         clk,
    input logic         rst,
    dm_access_unit_if.slave bus
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(NB);

    logic [1:0]            state_q,  state_d;
    logic                  write_q,  write_d;
    logic [1:0]            size_q,   size_d;
    logic                  signed_q, signed_d;
    logic [OFFW-1:0]       off_q,    off_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [NB-1:0]         be_q,     be_d;
    logic [DATA_WIDTH-1:0] din_q,    din_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  error_q,  error_d;

`ifdef DM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    logic                  idle;
    logic [1:0]            al_size;
    logic [OFFW-1:0]       al_off;
    logic                  al_signed;
    logic [NB-1:0]         al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic [2:0]            align_mask;
    logic                  misaligned;

    assign idle = (state_q == ST_IDLE);

    // The aligner serves the incoming request in IDLE and the latched one afterwards.
    always_comb begin
        al_size   = idle ? bus.req_size : size_q;
        al_off    = idle ? bus.req_addr[OFFW-1:0] : off_q;
        al_signed = idle ? bus.req_signed : signed_q;
    end

    dm_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i    (al_size),
        .offset_i  (al_off),
        .signed_i  (al_signed),
        .wdata_i   (bus.req_wdata),
        .rdata_i   (bus.DM_out),
        .byte_en_o (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    always_comb begin
        align_mask = 3'((4'd1 << bus.req_size) - 4'd1);
        misaligned = (|(bus.req_addr[2:0] & align_mask)) ||
                     ((DATA_WIDTH == 32) && (bus.req_size == SZ_DWORD));
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        addr_d   = addr_q;
        be_d     = be_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
`ifdef DM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    off_d    = bus.req_addr[OFFW-1:0];
                    addr_d   = bus.req_addr & ~ADDR_WIDTH'(NB - 1);
                    be_d     = misaligned ? '0 : al_be;
                    din_d    = (bus.req_write && !misaligned) ? al_wdata : '0;
                    rdata_d  = '0;
                    error_d  = misaligned;
                    state_d  = misaligned ? ST_RESP : ST_ACCESS;
`ifdef DM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (bus.DM_ready) begin
                    rdata_d = write_q ? '0 : al_rdata;
                    error_d = 1'b0;
                    state_d = ST_RESP;
`ifdef DM_TIMEOUT_EN
                end else if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            off_q    <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            din_q    <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
`ifdef DM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            din_q    <= din_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
`ifdef DM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.req_ready  = idle;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_error  = error_q;
    assign bus.DM_enable  = (state_q == ST_ACCESS);
    assign bus.DM_read    = (state_q == ST_ACCESS) && !write_q;
    assign bus.DM_write   = (state_q == ST_ACCESS) && write_q;
    assign bus.DM_address = addr_q;
    assign bus.DM_byte_en = be_q;
    assign bus.DM_in      = din_q;

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
Parametrised data-memory access unit between the core's memaccess stage and a wait-state data memory. It supersedes the fixed 32-bit word-only DM hookup with byte, halfword, word and (at 64-bit) doubleword accesses. Each access produces byte-lane enables, store-data replication, and sign or zero extension of load data. A request/response handshake stalls the core while memory inserts wait states, and misaligned accesses are flagged instead of issued.

Parameters:
ADDR_WIDTH, 12, byte address width.
DATA_WIDTH, 32, memory word width; legal values 32 or 64.
TIMEOUT_CYCLES, 16, wait-state limit; used only with DM_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  core presents an access
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only at 64)
req_signed  in  1  sign-extend load data
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  response available
rsp_ready  in  1  core consumes the response
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
rsp_error  out  1  misaligned access, illegal size, or timeout
DM_enable  out  1  memory access active
DM_read  out  1  memory read strobe
DM_write  out  1  memory write strobe
DM_address  out  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits are 0)
DM_byte_en  out  DATA_WIDTH/8  byte-lane write enables
DM_in  out  DATA_WIDTH  store data, replicated across lanes
DM_out  in  DATA_WIDTH  memory read data
DM_ready  in  1  memory completes the access this cycle

Behaviour:
- States: IDLE, ACCESS, RESP. On reset: state IDLE, req_ready=1, and all other outputs 0.
- IDLE: req_ready=1. When req_valid is 1, latch the request fields.
  - Misaligned request (addr mod 2^size != 0), or size 3 at DATA_WIDTH=32: go to RESP with rsp_error=1. No DM strobe is issued.
  - Otherwise go to ACCESS.
- ACCESS: req_ready=0. DM_enable=1, and DM_read or DM_write per req_write.
  - DM_address, DM_in and DM_byte_en come from registers and stay stable for the whole state.
  - Byte lanes: lane = addr low bits, width 2^size bytes.
  - Store data: req_wdata low 2^size bytes, replicated to every lane.
  - The unit remains in ACCESS until DM_ready=1. Zero wait states are allowed (DM_ready in the first ACCESS cycle).
  - On DM_ready: for a load, register DM_out shifted right by lane*8, masked to the size, then sign- or zero-extended. Go to RESP.
- RESP: rsp_valid=1, and rsp_rdata and rsp_error are held stable until rsp_ready=1. Then go to IDLE.
  - rsp_valid rises only on a clock edge and never in the same cycle as request acceptance.
- Minimum latency: accept at edge N, ACCESS during cycle N+1, rsp_valid from edge N+2 when DM_ready=1 in the first ACCESS cycle.
- Throughput: one access in flight. A new request cannot be accepted in the same cycle rsp_ready completes.
- rsp_ready while not in RESP: ignored. Changes to req_* after acceptance: ignored.
- DM_ready outside ACCESS: ignored.
- Reset asserted mid-access: immediate return to IDLE with DM strobes deasserted. A pending store may or may not reach memory.
- Word size at DATA_WIDTH=32, and dword at 64, use full-lane enables and no extension.

Optional Feature:
DM_TIMEOUT_EN
- Defined: a saturating counter, cleared on entering ACCESS, increments each ACCESS cycle without DM_ready.
  - On reaching TIMEOUT_CYCLES, go to RESP with rsp_error=1 and rsp_rdata=0. DM strobes drop.
  - DM_ready in the same cycle as the timeout wins, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package (dm_pkg):
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - state encoding;
  - function for the byte-enable mask;
  - function for load extract/extend.
- Sub-module: dm_lane_align, purely combinational. It computes byte_en, replicated store data and extended load data from size/offset/signed. It is reused by a future instruction-fetch unit.

Test Plan:
1. Word store, addr 0x104, wdata 0xDEADBEEF, DM_ready on first ACCESS cycle.
   -> DM_write=1, DM_address=0x104, DM_byte_en=4'b1111, DM_in=0xDEADBEEF; rsp_valid at accept+2 with rsp_error=0.
2. Signed byte load, addr 0x043, DM_out=0x80_12_34_56.
   -> DM_byte_en irrelevant, DM_read=1, DM_address=0x040; rsp_rdata=0xFFFFFF80.
   Same with req_signed=0 -> rsp_rdata=0x00000080.
3. Half store, addr 0x002, wdata 0x0000ABCD.
   -> DM_byte_en=4'b1100, DM_in=0xABCDABCD.
4. Half load at addr 0x001.
   -> rsp_error=1, no DM_enable pulse, rsp_valid held until rsp_ready asserted 3 cycles later.
5. Load with DM_ready withheld 5 cycles.
   -> DM strobes and address stable 6 cycles, req_ready=0 throughout.
   With DM_TIMEOUT_EN and TIMEOUT_CYCLES=4, withholding forever -> rsp_error=1 after 4 ACCESS cycles.
6. Assert rst low mid-ACCESS.
   -> DM_enable=0 and req_ready=1 immediately (asynchronous); a subsequent word load at 0x000 completes normally.
